// File: rtl/writeback_stage_if.sv
// writeback_stage_if: memory-stage to writeback-stage instruction payload bundle.
interface writeback_stage_if;
  logic        in_is_stall;
  logic [31:0] in_read_data;
  logic [31:0] in_reg_pc;
  logic [31:0] in_alu_out;
  logic        in_br_flg;
  logic [31:0] in_br_target;
  logic        in_rf_wen;
  logic [3:0]  in_wb_sel;
  logic [4:0]  in_wb_addr;
  logic        in_jmp_flg;
  logic        in_inst_is_ecall;
  modport master (output in_is_stall, in_read_data, in_reg_pc, in_alu_out, in_br_flg, in_br_target,
                  in_rf_wen, in_wb_sel, in_wb_addr, in_jmp_flg, in_inst_is_ecall);
  modport slave (input in_is_stall, in_read_data, in_reg_pc, in_alu_out, in_br_flg, in_br_target,
                 in_rf_wen, in_wb_sel, in_wb_addr, in_jmp_flg, in_inst_is_ecall);
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage; register-file write, branch redirect, retire count, ecall halt.
module writeback_stage #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  writeback_stage_if.slave     m,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 wb_branch_hazard,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic                 exit,
  output logic [31:0]          exit_code
);
  localparam logic [3:0] WB_X = 4'd0, WB_ALU = 4'd1, WB_MEM = 4'd2, WB_PC = 4'd3;
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        valid, s_wen, s_ecall;
  logic [31:0] s_rdata, s_pc, s_alu, gp;
  logic [3:0]  s_sel;
  logic [4:0]  s_addr;
  logic        cap, gp_wr;
  always_comb begin
    cap = state == RUN && !m.in_is_stall;
    rf_we = valid && s_wen && s_sel != WB_X && s_addr != 5'd0 && !s_ecall;
    rf_waddr = rf_we ? s_addr : 5'd0;
    rf_wdata = s_sel == WB_ALU ? s_alu : s_sel == WB_MEM ? s_rdata : s_sel == WB_PC ? s_pc + 32'd4 : 32'd0;
    gp_wr = rf_we && rf_waddr == 5'd3;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= 4'd0;
      valid <= 1'b0;
      s_wen <= 1'b0;
      s_ecall <= 1'b0;
      s_rdata <= 32'd0;
      s_pc <= 32'd0;
      s_alu <= 32'd0;
      s_sel <= WB_X;
      s_addr <= 5'd0;
      gp <= 32'd0;
      wb_branch_hazard <= 1'b0;
      redirect_pc <= 32'd0;
      retire_count <= '0;
      exit <= 1'b0;
      exit_code <= 32'd0;
    end else begin
      valid <= cap;
      if (cap) begin
        s_wen <= m.in_rf_wen;
        s_ecall <= m.in_inst_is_ecall;
        s_rdata <= m.in_read_data;
        s_pc <= m.in_reg_pc;
        s_alu <= m.in_alu_out;
        s_sel <= m.in_wb_sel;
        s_addr <= m.in_wb_addr;
        retire_count <= retire_count + CNT_WIDTH'(1);
      end
      if (gp_wr) gp <= rf_wdata;
      case (state)
        RUN: begin
          // ecall wins over a simultaneous branch; exit code sees a same-cycle x3 write
          if (cap && m.in_inst_is_ecall) begin
            state <= HALT;
            exit <= 1'b1;
            exit_code <= gp_wr ? rf_wdata : gp;
          end else if (cap && (m.in_br_flg || m.in_jmp_flg)) begin
            state <= FLUSH;
            wb_branch_hazard <= 1'b1;
            cnt <= 4'(FLUSH_CYCLES);
            redirect_pc <= m.in_br_target;
          end
        end
        FLUSH: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RUN;
            wb_branch_hazard <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
